// File: rtl/logic_sweep_pkg.sv
// Shared state encoding, MISR defaults and the MISR step function for the logic sweep sequencer.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDone
    } sweep_state_e;

    localparam int unsigned DefSigW = 16;
    localparam logic [15:0] DefPoly = 16'h1021;
    localparam logic [15:0] DefSeed = 16'hFFFF;

    // One MISR step for a register of 'width' bits (1..32); result bits above width are zero.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] resp,
                                              input logic [31:0] poly,
                                              input int unsigned width);
        logic [31:0] mask;
        logic [31:0] msb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        msb  = (sig >> (width - 1)) & 32'h1;
        return ((sig << 1) ^ ((msb != 32'h0) ? poly : 32'h0) ^ resp) & mask;
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register compacting the sampled network responses.
module sweep_misr
    import logic_sweep_pkg::*;
#(
    parameter int unsigned      SIG_W = DefSigW,
    parameter int unsigned      N_OUT = 3,
    parameter logic [SIG_W-1:0] POLY  = DefPoly,
    parameter logic [SIG_W-1:0] SEED  = DefSeed
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_seed,
    input  logic             en,
    input  logic [N_OUT-1:0] resp,
    output logic [SIG_W-1:0] signature
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = SIG_W'(misr_next(32'(sig_q), 32'(resp), 32'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps every input vector of a small logic network, checks each response against a
// truth table and compacts the responses into a MISR signature.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int unsigned                    N_IN      = 3,
    parameter int unsigned                    N_OUT     = 3,
    parameter int unsigned                    SETTLE    = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0]     EXP_TABLE = 'h200000,
    parameter int unsigned                    SIG_W     = DefSigW,
    parameter logic [SIG_W-1:0]               POLY      = DefPoly,
    parameter logic [SIG_W-1:0]               SEED      = DefSeed
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    mismatch_cnt,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned     CntW       = $clog2(SETTLE) + 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LastVec    = N_IN'((2**N_IN) - 1);

    sweep_state_e     state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    mcnt_q, mcnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             load_seed;
    logic             sample;
    logic [N_OUT-1:0] exp_resp;
    logic             miss;

    assign exp_resp = EXP_TABLE[32'(vec_q) * N_OUT +: N_OUT];
    assign miss     = (resp != exp_resp);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        mcnt_d       = mcnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        load_seed    = 1'b0;
        sample       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d      = StDrive;
                    vec_d        = '0;
                    cnt_d        = '0;
                    pass_d       = 1'b0;
                    mcnt_d       = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    load_seed    = 1'b1;
                end
            end
            StDrive: begin
                // Abort takes priority over the sample due on the same cycle.
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q == SettleLast) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (miss) begin
                        mcnt_d = mcnt_q + (N_IN+1)'(1);
                        if (!fail_seen_q) begin
                            fail_seen_d  = 1'b1;
                            first_fail_d = vec_q;
                        end
                    end
                    if (vec_q == LastVec) begin
                        state_d = StDone;
                        vec_d   = '0;
                        pass_d  = (mcnt_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            mcnt_q       <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            mcnt_q       <= mcnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (load_seed),
        .en        (sample),
        .resp      (resp),
        .signature (signature)
    );

    assign vec          = vec_q;
    assign busy         = (state_q == StDrive);
    assign done         = (state_q == StDone);
    assign pass         = pass_q;
    assign mismatch_cnt = mcnt_q;
    assign fail_seen    = fail_seen_q;
    assign first_fail   = first_fail_q;

endmodule
